// File: rtl/bf_pkg.sv
// -----------------------------------------------------------------------------
// bf_pkg
// Shared encodings for the BF chip bus protocol and the off-chip responder.
//   io_op_t     : chip io_out[10:8] state field (which header byte is on bus)
//   bus_op_t    : transaction opcode carried in the IoOpcode byte
//   rsp_state_t : responder FSM state
// -----------------------------------------------------------------------------
package bf_pkg;

  typedef enum logic [2:0] {
    IoNone      = 3'd0,
    IoOpcode    = 3'd1,
    IoAddrHi    = 3'd2,
    IoAddrLo    = 3'd3,
    IoReadWrite = 3'd4
  } io_op_t;

  typedef enum logic [2:0] {
    BusNone  = 3'd0,
    BusRead  = 3'd1,
    BusWrite = 3'd2,
    BusIn    = 3'd3,
    BusOut   = 3'd4
  } bus_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_TX   = 3'd2,
    S_RX   = 3'd3,
    S_DONE = 3'd4
  } rsp_state_t;

endpackage

// File: rtl/bf_tape_ram.sv
// -----------------------------------------------------------------------------
// bf_tape_ram
// Single-port byte memory holding program and tape. One synchronous
// read/write port; read data appears one cycle after the address (old data
// on a same-address write). Contents are never reset.
// Ports:
//   clock  : clock
//   we     : write strobe
//   addr   : byte address
//   wdata  : write byte
//   rdata  : registered read byte
// -----------------------------------------------------------------------------
module bf_tape_ram #(
  parameter int MEM_AW = 12
) (
  input  logic              clock,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**MEM_AW];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bf_bus_responder.sv
// -----------------------------------------------------------------------------
// bf_bus_responder
// Off-chip partner of the BF chip. Watches the chip's serialized bus header
// (opcode, addr hi, addr lo, read/write) on chip_io_out and services each
// transaction against a local byte memory or a console byte stream, returning
// {enable, op_done, bus_in} on chip_io_in.
// Ports:
//   clock, reset_n      : clock, asynchronous active-low reset
//   run                 : host lets the chip step (registered into enable)
//   chip_io_out[11:0]   : {halted, IoOp state[2:0], bus_out[7:0]} from chip
//   chip_io_in[11:0]    : {2'b0, enable, op_done, bus_in[7:0]} to chip
//   tx_data/valid/ready : console output stream (BusOut)
//   rx_data/valid/ready : console input stream (BusIn)
//   ld_we/addr/data     : host memory preload port (only while frozen + idle)
//   halted              : registered chip halted flag
//   err                 : sticky unknown-opcode flag
// -----------------------------------------------------------------------------
module bf_bus_responder
  import bf_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  input  logic [11:0]       chip_io_out,
  output logic [11:0]       chip_io_in,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              ld_we,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              halted,
  output logic              err
);

  rsp_state_t  state_q;
  logic        enable_q;
  logic [2:0]  opcode_q;
  logic [15:0] addr_q;
  logic [7:0]  bus_in_q;
  logic        op_done_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        rx_ready_q;
  logic        halted_q;
  logic        err_q;

  logic [2:0]        chip_state;
  logic [7:0]        bus_out;
  logic              in_idle;
  logic              rw_go;
  logic              chip_wr;
  logic              host_wr;
  logic              ram_we;
  logic [MEM_AW-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  assign chip_state = chip_io_out[10:8];
  assign bus_out    = chip_io_out[7:0];

  assign in_idle = (state_q == S_IDLE);
  assign rw_go   = enable_q && in_idle && (chip_state == IoReadWrite);
  assign chip_wr = rw_go && (opcode_q == BusWrite);
  // Host may only touch memory while the chip is frozen and nothing is in flight.
  assign host_wr = ld_we && !enable_q && in_idle;

  // The address latch normally drives the port, so a read issued in the
  // ReadWrite cycle already sees the complete latched address.
  assign ram_we    = chip_wr || host_wr;
  assign ram_addr  = host_wr ? ld_addr : addr_q[MEM_AW-1:0];
  assign ram_wdata = host_wr ? ld_data : bus_out;

  // Chip addresses wrap into the local memory; upper bits are latched only.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[15:MEM_AW];

  bf_tape_ram #(
    .MEM_AW (MEM_AW)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      enable_q   <= 1'b0;
      opcode_q   <= 3'd0;
      addr_q     <= 16'd0;
      bus_in_q   <= 8'd0;
      op_done_q  <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      enable_q <= run;
      halted_q <= chip_io_out[11];
      case (state_q)
        S_IDLE: begin
          if (enable_q) begin
            case (chip_state)
              IoOpcode: opcode_q      <= bus_out[2:0];
              IoAddrHi: addr_q[15:8]  <= bus_out;
              IoAddrLo: addr_q[7:0]   <= bus_out;
              IoReadWrite: begin
                case (opcode_q)
                  BusRead: begin
                    state_q <= S_RD;
                  end
                  BusWrite: begin
                    op_done_q <= 1'b1;
                    state_q   <= S_DONE;
                  end
                  BusOut: begin
                    tx_data_q  <= bus_out;
                    tx_valid_q <= 1'b1;
                    state_q    <= S_TX;
                  end
                  BusIn: begin
                    rx_ready_q <= 1'b1;
                    state_q    <= S_RX;
                  end
                  default: begin
                    op_done_q <= 1'b1;
                    bus_in_q  <= 8'd0;
                    err_q     <= 1'b1;
                    state_q   <= S_DONE;
                  end
                endcase
              end
              default: ;
            endcase
          end
        end
        S_RD: begin
          if (enable_q) begin
            bus_in_q  <= ram_rdata;
            op_done_q <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        // Console handshakes complete even while frozen; the result then
        // waits in S_DONE until the chip is running again.
        S_TX: begin
          if (tx_valid_q && tx_ready) begin
            tx_valid_q <= 1'b0;
            op_done_q  <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_RX: begin
          if (rx_valid && rx_ready_q) begin
            bus_in_q   <= rx_data;
            rx_ready_q <= 1'b0;
            op_done_q  <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        // op_done must survive one enabled cycle so the chip samples it.
        S_DONE: begin
          if (enable_q) begin
            op_done_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign chip_io_in = {2'b00, enable_q, op_done_q, bus_in_q};
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign rx_ready   = rx_ready_q;
  assign halted     = halted_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bf_bus_responder.sv
module tb_bf_bus_responder;
  import bf_pkg::*;

  localparam int MEM_AW = 12;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        run;
  logic [11:0] chip_io_out;
  logic [11:0] chip_io_in;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        ld_we;
  logic [11:0] ld_addr;
  logic [7:0]  ld_data;
  logic        halted;
  logic        err;

  always #5 clock = ~clock;

  bf_bus_responder #(.MEM_AW(MEM_AW)) dut (
    .clock(clock), .reset_n(reset_n), .run(run),
    .chip_io_out(chip_io_out), .chip_io_in(chip_io_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .halted(halted), .err(err)
  );

  int tests = 0;
  int failed = 0;

  // Reference model: memory image, last bus_in value, sticky error.
  logic [7:0]  mdl [4096];
  logic [11:0] wq [$];
  logic [7:0]  m_bus_in;
  logic        m_err;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [7:0]  val;
    int          d;
    logic [7:0]  rxb;
    logic [7:0]  exp_bi;
    int          exp_lat;
    int          exp_beats;
    logic [7:0]  exp_tx;
    logic        exp_err;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_io_in"},    32'(chip_io_in), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid),   32'd0);
    check({tag, "_tx_data"},  32'(tx_data),    32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready),   32'd0);
    check({tag, "_halted"},   32'(halted),     32'd0);
    check({tag, "_err"},      32'(err),        32'd0);
  endtask

  task automatic header(input logic [2:0] op, input logic [15:0] a);
    chip_io_out = {1'b0, 3'd1, 5'd0, op};  step();
    chip_io_out = {1'b0, 3'd2, a[15:8]};   step();
    chip_io_out = {1'b0, 3'd3, a[7:0]};    step();
  endtask

  // One complete chip transaction. Console sinks/sources become ready after
  // d cycles. lat counts cycles from the first ReadWrite cycle to op_done.
  task automatic txn(input logic [2:0] op, input logic [15:0] a, input logic [7:0] v,
                     input int d, input logic [7:0] rxb,
                     output logic [7:0] bi, output int lat, output int beats,
                     output logic [7:0] txb, output int hold_bad, output logic done_after);
    logic rx_taken;
    rx_taken = 1'b0;
    lat = 0; beats = 0; txb = 8'h00; hold_bad = 0;
    header(op, a);
    chip_io_out = {1'b0, 3'd4, v};
    while (1) begin
      step();
      lat++;
      if (chip_io_in[8]) break;
      if (lat > 200) begin
        check("txn_timeout", 32'(lat), 32'd0);
        break;
      end
      if (op == BusOut && !tx_valid) hold_bad++;
      if (op == BusIn && !rx_ready) hold_bad++;
      tx_ready = (lat > d);
      rx_valid = (lat > d) && !rx_taken;
      rx_data  = rxb;
      if (tx_valid && tx_ready) begin
        beats++;
        txb = tx_data;
      end
      if (rx_valid && rx_ready) rx_taken = 1'b1;
    end
    bi = chip_io_in[7:0];
    chip_io_out = 12'h000;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    step();
    done_after = chip_io_in[8];
  endtask

  function automatic int exp_lat(input logic [2:0] op, input int d);
    case (op)
      BusRead:       return 2;
      BusOut, BusIn: return d + 2;
      default:       return 1;
    endcase
  endfunction

  // Randomized transaction checked against the model.
  task automatic model_txn(input int k, input logic [2:0] op, input logic [15:0] a,
                           input logic [7:0] v, input int d, input logic [7:0] rxb);
    logic [7:0] bi, txb, e_bi;
    int lat, beats, hold_bad;
    logic done_after;
    case (op)
      BusRead:  e_bi = mdl[a[11:0]];
      BusWrite: e_bi = m_bus_in;
      BusOut:   e_bi = m_bus_in;
      BusIn:    e_bi = rxb;
      default: begin e_bi = 8'h00; m_err = 1'b1; end
    endcase
    txn(op, a, v, d, rxb, bi, lat, beats, txb, hold_bad, done_after);
    if (op == BusWrite) begin
      mdl[a[11:0]] = v;
      wq.push_back(a[11:0]);
    end
    m_bus_in = e_bi;
    check($sformatf("rnd%0d_op%0d_bus_in", k, op), 32'(bi), 32'(e_bi));
    check($sformatf("rnd%0d_lat", k), 32'(lat), 32'(exp_lat(op, d)));
    check($sformatf("rnd%0d_err", k), 32'(err), 32'(m_err));
    check($sformatf("rnd%0d_done_drop", k), 32'(done_after), 32'd0);
    if (op == BusOut) begin
      check($sformatf("rnd%0d_beats", k), 32'(beats), 32'd1);
      check($sformatf("rnd%0d_tx_data", k), 32'(txb), 32'(v));
    end
  endtask

  task automatic host_load(input logic [11:0] a, input logic [7:0] v);
    run = 1'b0; step();
    ld_we = 1'b1; ld_addr = a; ld_data = v; step();
    ld_we = 1'b0;
    run = 1'b1; step(); step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] bi, txb;
    int lat, beats, hold_bad;
    logic done_after;

    reset_n = 1'b0; run = 1'b0; chip_io_out = 12'h000;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    ld_we = 1'b0; ld_addr = 12'h000; ld_data = 8'h00;
    m_bus_in = 8'h00; m_err = 1'b0;
    for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;

    tbl[0] = '{BusRead,  16'h0012, 8'h00, 0, 8'h00, 8'hA5, 2, 0, 8'h00, 1'b0};
    tbl[1] = '{BusWrite, 16'hF034, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 1'b0};
    tbl[2] = '{BusRead,  16'h0034, 8'h00, 0, 8'h00, 8'h3C, 2, 0, 8'h00, 1'b0};
    tbl[3] = '{BusOut,   16'h0000, 8'h41, 5, 8'h00, 8'h3C, 7, 1, 8'h41, 1'b0};
    tbl[4] = '{BusIn,    16'h0000, 8'h00, 3, 8'h7E, 8'h7E, 5, 0, 8'h00, 1'b0};
    tbl[5] = '{BusWrite, 16'h0100, 8'h55, 0, 8'h00, 8'h7E, 1, 0, 8'h00, 1'b0};
    tbl[6] = '{BusRead,  16'h0100, 8'h00, 0, 8'h00, 8'h55, 2, 0, 8'h00, 1'b0};
    tbl[7] = '{3'd7,     16'h0000, 8'h99, 0, 8'h00, 8'h00, 1, 0, 8'h00, 1'b1};
    tbl[8] = '{BusRead,  16'h1012, 8'h00, 0, 8'h00, 8'hA5, 2, 0, 8'h00, 1'b1};
    tbl[9] = '{BusNone,  16'h0000, 8'h00, 0, 8'h00, 8'h00, 1, 0, 8'h00, 1'b1};

    step(); step();
    check_zero("reset");

    // Release reset frozen and preload.
    reset_n = 1'b1;
    ld_we = 1'b1; ld_addr = 12'h012; ld_data = 8'hA5; step();
    ld_we = 1'b0;
    mdl[12'h012] = 8'hA5;
    wq.push_back(12'h012);
    run = 1'b1; step(); step();
    check("enable_follows_run", 32'(chip_io_in[9]), 32'd1);

    for (int i = 0; i < 10; i++) begin
      txn(tbl[i].op, tbl[i].addr, tbl[i].val, tbl[i].d, tbl[i].rxb,
          bi, lat, beats, txb, hold_bad, done_after);
      check($sformatf("vec%0d_bus_in", i), 32'(bi), 32'(tbl[i].exp_bi));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
      check($sformatf("vec%0d_beats", i), 32'(beats), 32'(tbl[i].exp_beats));
      check($sformatf("vec%0d_hold", i), 32'(hold_bad), 32'd0);
      check($sformatf("vec%0d_done_drop", i), 32'(done_after), 32'd0);
      check($sformatf("vec%0d_hs_idle", i), 32'({tx_valid, rx_ready}), 32'd0);
      if (tbl[i].exp_beats != 0)
        check($sformatf("vec%0d_tx_data", i), 32'(txb), 32'(tbl[i].exp_tx));
      if (tbl[i].op == BusWrite) begin
        mdl[tbl[i].addr[11:0]] = tbl[i].val;
        wq.push_back(tbl[i].addr[11:0]);
      end
      m_bus_in = tbl[i].exp_bi;
      m_err    = tbl[i].exp_err;
    end

    // Host load while running must be ignored.
    ld_we = 1'b1; ld_addr = 12'h012; ld_data = 8'hFF; step();
    ld_we = 1'b0;
    model_txn(100, BusRead, 16'h0012, 8'h00, 0, 8'h00);

    // halted is a plain registered copy.
    chip_io_out = 12'h800; step();
    check("halted_set", 32'(halted), 32'd1);
    chip_io_out = 12'h000; step();
    check("halted_clr", 32'(halted), 32'd0);

    // BusIn completes while frozen; op_done waits until run returns.
    header(BusIn, 16'h0000);
    chip_io_out = {1'b0, 3'd4, 8'h00};
    step();
    run = 1'b0;
    step(); step();
    check("stall_enable_low", 32'(chip_io_in[9]), 32'd0);
    rx_valid = 1'b1; rx_data = 8'h7E;
    step();
    rx_valid = 1'b0;
    check("stall_rx_done", 32'(chip_io_in[8]), 32'd1);
    check("stall_bus_in", 32'(chip_io_in[7:0]), 32'h7E);
    check("stall_rx_ready_drop", 32'(rx_ready), 32'd0);
    step(); step(); step();
    check("stall_done_held", 32'(chip_io_in[8]), 32'd1);
    run = 1'b1;
    step();
    check("stall_done_first_enabled", 32'(chip_io_in[8]), 32'd1);
    chip_io_out = 12'h000;
    step();
    check("stall_done_release", 32'(chip_io_in[8]), 32'd0);
    m_bus_in = 8'h7E;

    // Randomized traffic against the model.
    for (int k = 0; k < 40; k++) begin
      int r;
      logic [15:0] a;
      logic [3:0] hi;
      r = $urandom_range(0, 9);
      a = 16'($urandom);
      hi = 4'($urandom);
      if (r <= 3) begin
        model_txn(k, BusWrite, a, 8'($urandom), 0, 8'h00);
      end else if (r <= 6) begin
        a = {hi, wq[$urandom_range(0, wq.size() - 1)]};
        model_txn(k, BusRead, a, 8'($urandom), 0, 8'h00);
      end else if (r == 7) begin
        model_txn(k, BusOut, a, 8'($urandom), $urandom_range(0, 3), 8'h00);
      end else if (r == 8) begin
        model_txn(k, BusIn, a, 8'h00, $urandom_range(0, 3), 8'($urandom));
      end else begin
        logic [7:0] v;
        v = 8'($urandom);
        host_load(a[11:0], v);
        mdl[a[11:0]] = v;
        wq.push_back(a[11:0]);
        model_txn(k, BusRead, a, 8'h00, 0, 8'h00);
      end
    end

    // Asynchronous reset in the middle of a console output.
    header(BusOut, 16'h0000);
    chip_io_out = {1'b0, 3'd4, 8'h41};
    step(); step();
    check("rst_tx_pending", 32'(tx_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_zero("rst_mid_tx");
    chip_io_out = 12'h000;
    step();
    reset_n = 1'b1;
    step(); step();
    m_err = 1'b0;
    m_bus_in = 8'h00;
    model_txn(200, BusRead, 16'h0012, 8'h00, 0, 8'h00);
    model_txn(201, BusOut, 16'h0000, 8'h5A, 1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
